vram_copy_arbiter: RTL and testbench
====================================

# vram_copy_arbiter

Shares the single-port 256×4 LCD video RAM between the CPU core and the per-frame snapshot copier. On each vsync it sequences a full 256-nibble read burst out of video RAM and streams `(addr, data, we)` into the frame buffer. The CPU keeps single-cycle access with priority over the burst. The block sits between the CPU bus decode, the video RAM and the frame buffer in the LCD path.

## Interface
Parameters:
- `COPY_WORDS`, default 256: nibbles per burst, covering addresses `0..COPY_WORDS-1`; must be ≤256.

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `cpu_req` in 1: CPU access request
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in 8: CPU address
- `cpu_wdata` in 4: CPU write data
- `cpu_ready` out 1: access accepted this cycle when `cpu_req && cpu_ready`
- `cpu_rdata` out 4: read data
- `cpu_rvalid` out 1: pulses one cycle after an accepted read
- `vsync` in 1: level; its rising edge starts a burst
- `ram_addr` out 8, `ram_we` out 1, `ram_wdata` out 4: video RAM port
- `ram_rdata` in 4: video RAM data, registered, 1-cycle latency
- `copy_addr` out 8, `copy_data` out 4, `copy_we` out 1: frame buffer write port
- `copy_busy` out 1: high in COPY and DRAIN
- `copy_done` out 1: one-cycle pulse at burst completion
- `overrun_count` out 8: saturating count of vsync edges ignored while busy

## Operation
- State machine:
  - IDLE: waits for a vsync rising edge, then moves to COPY. `issue_addr` is set to 0.
  - COPY: each cycle the RAM port is not taken by an accepted CPU access, the block issues a read of `issue_addr` and increments `issue_addr`. After issuing `COPY_WORDS-1`, it moves to DRAIN.
  - DRAIN: one cycle. The final copy write lands. `copy_done` pulses in this cycle and the state returns to IDLE.
- Port mux:
  - An accepted CPU access drives `ram_addr/ram_we/ram_wdata` from the CPU.
  - Otherwise, in COPY, the port carries the copy read with `ram_we=0`.
  - Otherwise the port idles with `ram_addr=0` and `ram_we=0`.
- `cpu_ready` is 1 in all states (CPU priority). Each accepted CPU access stalls the burst by one cycle.
- Copy pipeline: a copy read issued in cycle N produces, in cycle N+1, `copy_we=1`, `copy_addr=A`, `copy_data=ram_rdata`. Addresses are written strictly ascending with no gaps or repeats.
- CPU read pipeline: a read accepted in cycle N gives `cpu_rvalid=1` and `cpu_rdata=ram_rdata` in cycle N+1. `cpu_rdata` holds its value until the next read.
- CPU writes go to RAM in the accept cycle. The frame buffer gets the new value only if the write's address had not yet been issued by the burst.
- Edge detect: a registered `vsync_d` is kept; the edge is `vsync && !vsync_d`. A level held high never retriggers.
- Overrun: an edge seen in COPY or DRAIN is ignored and increments `overrun_count`, which saturates at 255. The count is cleared only by reset.
- Arithmetic: `issue_addr` is 9 bits internally so the `COPY_WORDS=256` terminal compare does not wrap.

## Timing
- Reset values:
  - state IDLE
  - `cpu_ready=1`; all other outputs 0
  - `vsync_d=0`, `overrun_count=0`
- A reset asserted mid-burst aborts it immediately. No `copy_done` is produced and no further `copy_we` occurs after the reset cycle.
- Uncontended burst:
  - edge in cycle T → COPY at T+1
  - reads issued T+1..T+COPY_WORDS
  - DRAIN at T+COPY_WORDS+1, with the last `copy_we` and `copy_done` there
  - IDLE at T+COPY_WORDS+2
- Each accepted CPU access during COPY adds exactly one cycle to the burst.
- `copy_busy` is high from T+1 through the DRAIN cycle inclusive.
- An edge arriving in the same cycle the state returns to IDLE (the cycle after DRAIN) starts a new burst and is not counted as an overrun.

## Configuration
- `VRAM_ATOMIC_COPY_EN` undefined (default): the CPU has priority as described above. A frame may mix pre- and post-write data.
- `VRAM_ATOMIC_COPY_EN` defined:
  - `cpu_ready=0` in COPY and DRAIN, so CPU requests are held off and never accepted.
  - The burst runs exactly `COPY_WORDS+2` cycles from the edge to the return to IDLE.
  - A CPU access accepted in the vsync-edge cycle itself still completes normally.

## Test plan
- Reset, then a vsync edge with no CPU traffic and RAM preloaded with `addr[3:0]` → 256 `copy_we` pulses, `copy_addr` 0..255, `copy_data = addr[3:0]`, `copy_done` at edge+257, `copy_busy` low at edge+258.
- During a burst, a CPU write of 0xA to address 0x80 at the cycle the burst issues 0x10, plus 3 CPU reads → frame buffer holds 0xA at 0x80, burst lengthened by exactly 4 cycles, each `cpu_rvalid` one cycle after its accept.
- Second vsync edge at edge+100 while busy, then a third immediately after DRAIN → `overrun_count=1`; the third edge starts a new burst. Also 300 ignored edges → `overrun_count` saturates at 255.
- `vsync` held high for 1000 cycles → exactly one burst, `overrun_count=0`.
- `reset` pulsed at burst address 0x40 → no `copy_we` after the reset cycle, no `copy_done`, all outputs at reset values; the next vsync edge restarts the burst at 0.
- With `VRAM_ATOMIC_COPY_EN` defined and `cpu_req` held high throughout → `cpu_ready=0` for the whole burst, burst length exactly 258 cycles, and the CPU access is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/vram_copy_arbiter.sv
// Arbitrates the single-port LCD video RAM between CPU accesses and the per-vsync snapshot burst into the frame buffer.
// Optional build macro VRAM_ATOMIC_COPY_EN holds the CPU off for the whole burst so each frame is a consistent snapshot.
module vram_copy_arbiter #(
  parameter int COPY_WORDS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic       cpu_ready,
  output logic [3:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       vsync,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata,
  output logic [7:0] copy_addr,
  output logic [3:0] copy_data,
  output logic       copy_we,
  output logic       copy_busy,
  output logic       copy_done,
  output logic [7:0] overrun_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [8:0] LAST_ADDR = 9'(COPY_WORDS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [8:0] issue_addr;
  logic       vsync_d;
  logic       vsync_edge;
  logic       cpu_acc;
  logic       copy_issue;
  logic       copy_pend;
  logic [7:0] copy_addr_q;
  logic       cpu_rd_pend;
  logic [3:0] cpu_rdata_q;
  logic [7:0] overrun_q;

  assign vsync_edge = vsync && !vsync_d;

`ifdef VRAM_ATOMIC_COPY_EN
  assign cpu_ready = (state == IDLE);
`else
  assign cpu_ready = 1'b1;
`endif

  assign cpu_acc = cpu_req && cpu_ready;

  // Port mux and next state; an accepted CPU access always wins the RAM port.
  always_comb begin
    state_nxt  = state;
    copy_issue = 1'b0;
    ram_addr   = 8'd0;
    ram_we     = 1'b0;
    ram_wdata  = 4'd0;
    if (cpu_acc) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (state == COPY) begin
      copy_issue = 1'b1;
      ram_addr   = issue_addr[7:0];
    end
    case (state)
      IDLE: begin
        if (vsync_edge) state_nxt = COPY;
      end
      COPY: begin
        if (copy_issue && (issue_addr == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      issue_addr  <= 9'd0;
      vsync_d     <= 1'b0;
      copy_pend   <= 1'b0;
      copy_addr_q <= 8'd0;
      cpu_rd_pend <= 1'b0;
      cpu_rdata_q <= 4'd0;
      overrun_q   <= 8'd0;
    end else begin
      state   <= state_nxt;
      vsync_d <= vsync;
      if ((state == IDLE) && vsync_edge) begin
        issue_addr <= 9'd0;
      end else if (copy_issue) begin
        issue_addr <= issue_addr + 9'd1;
      end
      // RAM read data arrives one cycle after the address, so tag it here.
      copy_pend <= copy_issue;
      if (copy_issue) copy_addr_q <= issue_addr[7:0];
      cpu_rd_pend <= cpu_acc && !cpu_we;
      if (cpu_rd_pend) cpu_rdata_q <= ram_rdata;
      if (vsync_edge && (state != IDLE) && (overrun_q != 8'hFF)) begin
        overrun_q <= overrun_q + 8'd1;
      end
    end
  end

  assign copy_we       = copy_pend;
  assign copy_addr     = copy_pend ? copy_addr_q : 8'd0;
  assign copy_data     = copy_pend ? ram_rdata : 4'd0;
  assign cpu_rvalid    = cpu_rd_pend;
  // Live RAM data on the response cycle, then held until the next read.
  assign cpu_rdata     = cpu_rd_pend ? ram_rdata : cpu_rdata_q;
  assign copy_busy     = (state == COPY) || (state == DRAIN);
  assign copy_done     = (state == DRAIN);
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_vram_copy_arbiter.sv
// Directed bench for vram_copy_arbiter: burst timing, CPU priority, overruns, vsync level hold and mid-burst reset.
module tb_vram_copy_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'd0;
  logic [3:0] cpu_wdata = 4'd0;
  logic       cpu_ready;
  logic [3:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       vsync = 1'b0;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic [7:0] copy_addr;
  logic [3:0] copy_data;
  logic       copy_we;
  logic       copy_busy;
  logic       copy_done;
  logic [7:0] overrun_count;

  logic       ram_init = 1'b1;
  logic [3:0] mem [256];
  logic [3:0] fb [256];
  logic [3:0] exp_q [$];
  int         acc_q [$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         copy_cnt = 0;
  int         done_cnt = 0;
  int         exp_next = 0;
  int         t0 = 0;

  vram_copy_arbiter #(.COPY_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vsync(vsync),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .copy_addr(copy_addr), .copy_data(copy_data), .copy_we(copy_we),
    .copy_busy(copy_busy), .copy_done(copy_done), .overrun_count(overrun_count)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // video RAM model: registered read, write in the address cycle, preloaded with addr[3:0]
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input int obs_v, input int exp_v);
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", tag, obs_v, exp_v, cyc);
    end
  endtask

  // scoreboard: CPU read data / latency, frame buffer capture and copy ordering
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_spurious", 1, 0);
      end else begin
        check("cpu_rdata", cpu_rdata, exp_q.pop_front());
        check("rvalid_lat", cyc - acc_q.pop_front(), 1);
      end
    end
    if (copy_we) begin
      check("copy_order", copy_addr, exp_next);
      fb[copy_addr] = copy_data;
      exp_next++;
      copy_cnt++;
    end
    if (copy_done) done_cnt++;
    if (copy_done || reset) exp_next = 0;
`ifdef VRAM_ATOMIC_COPY_EN
    if (copy_busy) check("atomic_ready", cpu_ready, 0);
`endif
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
    end else if (cpu_req && cpu_ready && !cpu_we) begin
      exp_q.push_back(mem[cpu_addr]);
      acc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
    #1;
  endtask

  task automatic start_edge(output int base_copy);
    step();
    vsync = 1'b1;
    t0 = cyc;
    base_copy = copy_cnt;
    obs();
    check("edge_idle", copy_busy, 0);
    step();
    vsync = 1'b0;
    obs();
    check("busy_after_edge", copy_busy, 1);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (copy_done) begin
        lat = cyc - t0;
        break;
      end
      obs();
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic find_issue(input logic [7:0] a, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      if (copy_busy && !copy_done && !ram_we && (ram_addr == a)) begin
        found = 1;
        break;
      end
      obs();
    end
    check(tag, found, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cpu_ready, 1);
    check({tag, "_busy"}, copy_busy, 0);
    check({tag, "_done"}, copy_done, 0);
    check({tag, "_copy_we"}, copy_we, 0);
    check({tag, "_copy_addr"}, copy_addr, 0);
    check({tag, "_copy_data"}, copy_data, 0);
    check({tag, "_rvalid"}, cpu_rvalid, 0);
    check({tag, "_rdata"}, cpu_rdata, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_overrun"}, overrun_count, 0);
  endtask

  initial begin
    int lat;
    int bc;
    int bd;
    int bad;

    // reset and reset values
    step();
    step();
    ram_init = 1'b0;
    obs();
    check_reset_outputs("rst");
    step();
    reset = 1'b0;

    // uncontended burst over the preloaded RAM
    start_edge(bc);
    wait_done(lat);
    check("t1_lat", lat, 257);
    check("t1_copies", copy_cnt - bc, 256);
    obs();
    check("t1_busy_end", copy_busy, 0);
    check("t1_done_pulse", copy_done, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (fb[i] !== 4'(i)) bad++;
    check("t1_fb_bad", bad, 0);

`ifdef VRAM_ATOMIC_COPY_EN
    // CPU held requesting across a whole atomic burst
    step();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 8'h01;
    start_edge(bc);
    wait_done(lat);
    check("at_lat", lat, 257);
    check("at_copies", copy_cnt - bc, 256);
    obs();
    check("at_idle_ready", cpu_ready, 1);
    check("at_idle_busy", copy_busy, 0);
    step();
    cpu_req = 1'b0;
    obs();
`else
    // CPU write to a not-yet-copied address plus three reads mid-burst
    start_edge(bc);
    find_issue(8'h0F, "t2_find");
    step();
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 8'h80;
    cpu_wdata = 4'hA;
    obs();
    check("t2_wr_addr", ram_addr, 8'h80);
    check("t2_wr_we", ram_we, 1);
    check("t2_wr_data", ram_wdata, 4'hA);
    step();
    cpu_we = 1'b0;
    cpu_addr = 8'h80;
    step();
    cpu_addr = 8'h05;
    step();
    cpu_addr = 8'h33;
    obs();
    check("t2_rd_addr", ram_addr, 8'h33);
    step();
    cpu_req = 1'b0;
    obs();
    check("t2_resume_addr", ram_addr, 8'h10);
    check("t2_rdata_last", cpu_rdata, 4'h3);
    obs();
    check("t2_rdata_hold", cpu_rdata, 4'h3);
    wait_done(lat);
    check("t2_lat", lat, 261);
    check("t2_copies", copy_cnt - bc, 256);
    check("t2_fb_80", fb[8'h80], 4'hA);
    check("t2_fb_7f", fb[8'h7F], 4'hF);
    check("t2_fb_10", fb[8'h10], 4'h0);
    obs();

    // overrun while busy, then an edge right after DRAIN
    start_edge(bc);
    for (int i = 0; i < 99; i++) step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    wait_done(lat);
    check("t3_lat", lat, 257);
    check("t3_overrun1", overrun_count, 1);
    step();
    vsync = 1'b1;
    obs();
    check("t3_edge_idle", copy_busy, 0);
    t0 = cyc;
    step();
    vsync = 1'b0;
    obs();
    check("t3_restart_busy", copy_busy, 1);
    check("t3_not_counted", overrun_count, 1);
    // CPU reads stall the burst while 300 more edges arrive
    step();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 8'h00;
    for (int i = 0; i < 300; i++) begin
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
    end
    obs();
    check("t3_saturate", overrun_count, 255);
    check("t3_stalled_busy", copy_busy, 1);
    step();
    cpu_req = 1'b0;
    wait_done(lat);
    obs();
    check("t3_sat_hold", overrun_count, 255);
`endif

    // vsync level held high: one burst only
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    obs();
    check("t4_overrun_clr", overrun_count, 0);
    bd = done_cnt;
    step();
    vsync = 1'b1;
    for (int i = 0; i < 1000; i++) step();
    vsync = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t4_one_burst", done_cnt - bd, 1);
    check("t4_overrun", overrun_count, 0);

    // reset in the cycle the burst issues 0x40
    start_edge(bc);
    find_issue(8'h3F, "t5_find");
    step();
    reset = 1'b1;
    bd = done_cnt;
    step();
    reset = 1'b0;
    bc = copy_cnt;
    obs();
    check_reset_outputs("t5");
    for (int i = 0; i < 20; i++) obs();
    check("t5_no_copy", copy_cnt - bc, 0);
    check("t5_no_done", done_cnt - bd, 0);
    start_edge(bc);
    wait_done(lat);
    check("t5_lat", lat, 257);
    check("t5_copies", copy_cnt - bc, 256);

    for (int i = 0; i < 3; i++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
